// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, DU-loadable instruction memory and the IF/ID register.
// Optional macro IF_BRANCH_FLUSH_EN: squash the fall-through fetch on a taken branch/jump (no delay slot).
module if_stage #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_stall,
  input  logic                         i_pc_src,
  input  logic [31:0]                  i_beq_jump_dir,
  input  logic                         i_jump,
  input  logic                         i_halt,
  input  logic                         i_du_mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_du_mem_addr,
  input  logic [31:0]                  i_du_mem_data,
  output logic [31:0]                  o_instruction,
  output logic [31:0]                  o_pc_plus_4,
  output logic [31:0]                  o_pc,
  output logic                         o_halted
);

  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_mem [MEM_DEPTH];
  logic [31:0] r_pc, r_instr, r_pc4;
  logic [31:0] w_pc_nxt, w_instr_nxt, w_pc4_nxt;
  logic [31:0] w_fetch, w_pc_seq, w_jump_tgt;

  assign w_fetch    = r_mem[r_pc[ADDR_W+1:2]];
  assign w_pc_seq   = r_pc + 32'd4;
  assign w_jump_tgt = {r_pc4[31:28], r_instr[25:0], 2'b00};

  // Memory is deliberately outside the reset domain so a loaded program survives reset.
  always_ff @(posedge i_clk) begin
    if (i_du_mem_we && !i_reset) begin
      r_mem[i_du_mem_addr] <= i_du_mem_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    if (r_state == S_RUN && i_enable && !i_stall) begin
      if (i_halt) begin
        w_state_nxt = S_HALT;
        w_instr_nxt = '0;
        w_pc4_nxt   = '0;
      end else begin
        if (i_jump) begin
          w_pc_nxt = w_jump_tgt;
        end else if (i_pc_src) begin
          w_pc_nxt = i_beq_jump_dir;
        end else begin
          w_pc_nxt = w_pc_seq;
        end
`ifdef IF_BRANCH_FLUSH_EN
        if (i_jump || i_pc_src) begin
          w_instr_nxt = '0;
          w_pc4_nxt   = '0;
        end else begin
          w_instr_nxt = w_fetch;
          w_pc4_nxt   = w_pc_seq;
        end
`else
        w_instr_nxt = w_fetch;
        w_pc4_nxt   = w_pc_seq;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_pc4   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
    end
  end

  assign o_instruction = r_instr;
  assign o_pc_plus_4   = r_pc4;
  assign o_pc          = r_pc;
  assign o_halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan sequences plus randomized traffic
// compared against a sequential behavioural model of the fetch stage.
module tb_if_stage;

`ifdef IF_BRANCH_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_stall, i_pc_src, i_jump, i_halt, i_du_mem_we;
  logic [31:0] i_beq_jump_dir, i_du_mem_data;
  logic [7:0]  i_du_mem_addr;
  logic [31:0] o_instruction, o_pc_plus_4, o_pc;
  logic        o_halted;

  if_stage #(.MEM_DEPTH(256), .RESET_PC(32'h0000_0000)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
    .i_pc_src(i_pc_src), .i_beq_jump_dir(i_beq_jump_dir), .i_jump(i_jump),
    .i_halt(i_halt), .i_du_mem_we(i_du_mem_we), .i_du_mem_addr(i_du_mem_addr),
    .i_du_mem_data(i_du_mem_data), .o_instruction(o_instruction),
    .o_pc_plus_4(o_pc_plus_4), .o_pc(o_pc), .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state: what decode should see, plus a full copy of program memory.
  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_h;
  logic [31:0] m_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".instr"},  o_instruction, m_ins);
    check({tag, ".pc4"},    o_pc_plus_4,   m_p4);
    check({tag, ".pc"},     o_pc,          m_pc);
    check({tag, ".halted"}, {31'b0, o_halted}, {31'b0, m_h});
  endtask

  // One clock: drive inputs after a falling edge, predict, then check after the rising edge.
  task automatic cycle(input string tag, input logic en, input logic st, input logic src,
                       input logic [31:0] dir, input logic jmp, input logic hlt,
                       input logic we, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] fetched, target, n_pc, n_ins, n_p4;
    logic        n_h;
    i_enable = en; i_stall = st; i_pc_src = src; i_beq_jump_dir = dir;
    i_jump = jmp; i_halt = hlt; i_du_mem_we = we; i_du_mem_addr = a; i_du_mem_data = d;
    fetched = m_mem[(m_pc / 4) % 256];
    target  = (m_p4 & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) * 4);
    n_pc = m_pc; n_ins = m_ins; n_p4 = m_p4; n_h = m_h;
    if (m_h || !en || st) begin
      // frozen
    end else if (hlt) begin
      n_h = 1'b1; n_ins = 32'h0; n_p4 = 32'h0;
    end else begin
      if (jmp)      n_pc = target;
      else if (src) n_pc = dir;
      else          n_pc = m_pc + 32'd4;
      if ((jmp || src) && FLUSH) begin
        n_ins = 32'h0; n_p4 = 32'h0;
      end else begin
        n_ins = fetched; n_p4 = m_pc + 32'd4;
      end
    end
    if (we) m_mem[a] = d;
    @(posedge i_clk);
    #1;
    m_pc = n_pc; m_ins = n_ins; m_p4 = n_p4; m_h = n_h;
    check_all(tag);
    @(negedge i_clk);
    i_du_mem_we = 1'b0;
  endtask

  task automatic idle_inputs();
    i_enable = 1'b0; i_stall = 1'b0; i_pc_src = 1'b0; i_beq_jump_dir = 32'h0;
    i_jump = 1'b0; i_halt = 1'b0; i_du_mem_we = 1'b0; i_du_mem_addr = 8'h0; i_du_mem_data = 32'h0;
  endtask

  // Async reset pulse spanning one rising edge; an optional DU write on that edge must be dropped.
  task automatic do_reset(input logic we, input logic [7:0] a, input logic [31:0] d);
    idle_inputs();
    i_reset = 1'b1;
    #1;
    m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_h = 1'b0;
    check_all("reset_async");
    i_du_mem_we = we; i_du_mem_addr = a; i_du_mem_data = d;
    @(posedge i_clk);
    #1;
    check_all("reset_hold");
    @(negedge i_clk);
    i_du_mem_we = 1'b0;
    i_reset = 1'b0;
  endtask

  task automatic du_write(input logic [7:0] a, input logic [31:0] d);
    cycle("du_write", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic run(input string tag, input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      cycle(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  initial begin
    idle_inputs();
    i_reset = 1'b1;
    m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_h = 1'b0;
    #1;
    check_all("por");
    @(negedge i_clk);
    i_reset = 1'b0;

    // Preload whole memory so the model knows every word.
    for (int unsigned w = 0; w < 256; w++) du_write(w[7:0], $urandom);
    du_write(8'd0, 32'h2001_0005);
    du_write(8'd1, 32'h2002_000A);
    du_write(8'd3, 32'h1234_5678);

    // Load-then-run
    run("run1", 1);
    check("tp_edge1_instr", o_instruction, 32'h2001_0005);
    check("tp_edge1_pc4",   o_pc_plus_4,   32'h4);
    check("tp_edge1_pc",    o_pc,          32'h4);
    run("run2", 1);
    check("tp_edge2_instr", o_instruction, 32'h2002_000A);
    check("tp_edge2_pc4",   o_pc_plus_4,   32'h8);

    // Stall at PC=8 for two edges, branch at PC=12
    cycle("stall", 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 8'h0, 32'h0);
    cycle("stall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    check("stall_pc", o_pc, 32'h8);
    check("stall_instr", o_instruction, 32'h2002_000A);
    run("resume", 1);
    check("resume_pc4", o_pc_plus_4, 32'hC);
    cycle("branch", 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    check("branch_pc", o_pc, 32'h40);
    check("branch_slot", o_instruction, FLUSH ? 32'h0 : 32'h1234_5678);

    // Jump wins over branch; same-edge DU write to the fetched word gives old data
    do_reset(1'b1, 8'd0, 32'hDEAD_BEEF);
    du_write(8'd1, 32'h0800_0010);
    run("jpre", 2);
    check("jpre_instr", o_instruction, 32'h0800_0010);
    cycle("jump", 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 8'd2, 32'hCAFE_0002);
    check("jump_pc", o_pc, 32'h40);

    // Halt at PC=20
    do_reset(1'b0, 8'd0, 32'h0);
    du_write(8'd4, 32'h1111_0004);
    run("hpre", 5);
    cycle("halt", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h0, 32'h0);
    check("halt_pc", o_pc, 32'd20);
    check("halt_flag", {31'b0, o_halted}, 32'h1);
    check("halt_nop", o_instruction, 32'h0);
    cycle("halted", 1'b1, 1'b0, 1'b1, 32'h88, 1'b1, 1'b0, 1'b0, 8'h0, 32'h0);
    run("halted", 2);
    check("halted_pc", o_pc, 32'd20);
    do_reset(1'b0, 8'd0, 32'h0);

    // Wrap: jump to 0x400 fetches word 0
    du_write(8'd5, 32'h0800_0100);
    run("wpre", 6);
    cycle("wjump", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0, 32'h0);
    check("wrap_pc", o_pc, 32'h400);
    run("wrap", 1);
    check("wrap_fetch", o_instruction, m_mem[0]);
    check("wrap_pc4", o_pc_plus_4, 32'h404);

    // PC 32-bit wrap
    cycle("top", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    run("top", 2);

    // Randomized traffic
    for (int unsigned n = 0; n < 600; n++) begin
      logic [31:0] dir;
      if (m_h && ($urandom % 4 == 0)) begin
        do_reset($urandom % 2 == 0, 8'($urandom), $urandom);
      end else begin
        dir = ($urandom % 3 == 0) ? $urandom : ($urandom & 32'h0000_03FC);
        cycle("rand", $urandom % 8 != 0, $urandom % 5 == 0, $urandom % 4 == 0, dir,
              $urandom % 6 == 0, $urandom % 30 == 0, $urandom % 3 == 0,
              8'($urandom), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It holds the program counter and a word-addressed instruction memory that the debug unit can load. It also holds the IF/ID pipeline register that feeds decode with the instruction and PC+4. It resolves the next PC from decode's branch/jump/stall/halt feedback and freezes the pipeline front end on HALT.

## Interface
- `MEM_DEPTH`, default 256: instruction memory size in 32-bit words; power of two. `ADDR_W = $clog2(MEM_DEPTH)`.
- `RESET_PC`, default 32'h0000_0000: PC value after reset.

Ports (clock and reset first):
- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_enable`  in  1  debug-unit run/step enable; 0 freezes PC, IF/ID and the halt latch.
- `i_stall`  in  1  load-use/branch hazard stall from decode.
- `i_pc_src`  in  1  taken conditional branch (BEQ/BNE) resolved in decode.
- `i_beq_jump_dir`  in  32  branch target from decode.
- `i_jump`  in  1  J/JAL decoded for the instruction currently in IF/ID.
- `i_halt`  in  1  HALT decoded for the instruction currently in IF/ID.
- `i_du_mem_we`  in  1  debug-unit instruction-memory write strobe.
- `i_du_mem_addr`  in  ADDR_W  debug-unit word address.
- `i_du_mem_data`  in  32  debug-unit write data.
- `o_instruction`  out  32  IF/ID instruction.
- `o_pc_plus_4`  out  32  IF/ID PC+4 of that instruction.
- `o_pc`  out  32  current PC (debug visibility).
- `o_halted`  out  1  sticky halt flag.

## Operation
- Fetch: `imem[pc[ADDR_W+1:2]]` is an asynchronous read. PC bits [1:0] are ignored. Addresses at or beyond `MEM_DEPTH` words wrap modulo `MEM_DEPTH`.
- The jump target is formed internally from IF/ID contents: {`o_pc_plus_4[31:28]`, `o_instruction[25:0]`, 2'b00}.
- Next-state priority per rising edge, highest first:
  1. `o_halted`=1 or `i_enable`=0: PC, IF/ID and halt flag hold.
  2. `i_stall`=1: PC and IF/ID hold. Any simultaneous `i_pc_src`/`i_jump`/`i_halt` is ignored this cycle; decode re-evaluates next cycle.
  3. `i_halt`=1: `o_halted`<=1, PC holds, IF/ID <= NOP (32'h0, PC+4 32'h0).
  4. `i_jump`=1: PC <= jump target. Jump wins over a simultaneous `i_pc_src`.
  5. `i_pc_src`=1: PC <= `i_beq_jump_dir`.
  6. Otherwise PC <= PC+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
- IF/ID load in cases 4–6: per Configuration. In case 6 it is {imem[PC], PC+4}.
- Halt state: `o_halted` is sticky and is cleared only by `i_reset`. Downstream stages keep draining because the stage feeds NOPs while halted.
- Debug-unit writes:
  - Synchronous: on the edge where `i_du_mem_we`=1, `imem[i_du_mem_addr]` <= `i_du_mem_data`.
  - Accepted regardless of `i_enable` or `o_halted`.
  - A fetch from the same word on that edge captures the old contents.

## Timing
- Reset (asynchronous, immediate): PC=`RESET_PC`, `o_instruction`=0, `o_pc_plus_4`=0, `o_halted`=0. Instruction memory is not cleared by reset, so a loaded program survives.
- Reset asserted mid-operation overrides everything, including a same-edge DU write: the write is dropped.
- Latency: the instruction at PC appears on `o_instruction` one cycle after PC holds it.
- Branch/jump redirect: the target instruction reaches IF/ID two edges after the branch sits in IF/ID.
- `o_pc` changes only on clock edges or reset; it never glitches combinationally.

## Configuration
- `IF_BRANCH_FLUSH_EN` defined:
  - On a redirect edge (cases 4–5), IF/ID <= NOP (32'h0, PC+4 32'h0), squashing the sequentially fetched instruction.
  - One bubble per taken branch/jump.
- Undefined (MIPS delay-slot semantics):
  - On a redirect edge, IF/ID <= {imem[PC], PC+4}, so the delay-slot instruction executes.
  - No bubble.

## Test plan
- Reset then load: DU writes 32'h2001_0005 at word 0 and 32'h2002_000A at word 1, then `i_enable`=1. Response:
  - edge 1: `o_instruction`=32'h2001_0005, `o_pc_plus_4`=4, `o_pc`=4;
  - edge 2: `o_instruction`=32'h2002_000A, `o_pc_plus_4`=8.
- Stall: with PC=8, hold `i_stall`=1 for 2 edges. Response: PC stays 8 and IF/ID is unchanged; on release the fetch resumes at word 2.
- Branch: with PC=12, pulse `i_pc_src`=1 with target 32'h40. Response: PC=32'h40 next edge. IF/ID is NOP with the macro, or imem[3] without it.
- Jump over branch: `i_jump`=1 and `i_pc_src`=1 together, IF/ID instr 32'h0800_0010, `o_pc_plus_4`=8. Response: PC=32'h40 (jump target), not the branch target.
- Halt: with PC=20, `i_halt`=1. Response:
  - `o_halted`=1, PC stays 20, IF/ID=NOP;
  - further `i_enable`/`i_pc_src` pulses change nothing;
  - `i_reset` clears everything to the reset values.
- Wrap: with `MEM_DEPTH`=256, jump to PC=32'h400. Response: the fetch returns imem[0].
